// File: rtl/rfdc_info_ctrlport_arb_pkg.sv
// rfdc_info_ctrlport_arb_pkg: shared types and status codes for the RFDC info ctrlport arbiter
package rfdc_info_ctrlport_arb_pkg;
  localparam logic [1:0] CTRL_STS_OKAY   = 2'b00;
  localparam logic [1:0] CTRL_STS_CMDERR = 2'b01;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef struct packed {
    logic [19:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] data;
    logic        is_wr;
  } slot_t;
  // prio names the port preferred when both slots are pending
  function automatic logic arb_pick(logic [1:0] pend, logic prio, logic fixed);
    return &pend ? (fixed ? 1'b0 : prio) : pend[1];
  endfunction
endpackage

// File: rtl/rfdc_info_ctrlport_arb_req_slot.sv
// rfdc_info_req_slot: single-entry request latch with sticky overlap flag
module rfdc_info_req_slot
  import rfdc_info_ctrlport_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] addr,
  input  logic [3:0]  byte_en,
  input  logic [31:0] data,
  input  logic        rd,
  input  logic        wr,
  input  logic        clr,
  output logic        pending,
  output slot_t       slot,
  output logic        overlap
);
  logic req;
  assign req = rd | wr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= 1'b0;
      slot    <= '0;
      overlap <= 1'b0;
    end else begin
      if (req && pending) overlap <= 1'b1;
      if (req && !pending) begin
        pending <= 1'b1;
        slot    <= '{addr, byte_en, data, wr & ~rd};
      end else if (clr) pending <= 1'b0;
    end
endmodule

// File: rtl/rfdc_info_ctrlport_arb.sv
// rfdc_info_ctrlport_arb: arbitrates two ctrlport requesters onto the read-only RFDC info memory
module rfdc_info_ctrlport_arb
  import rfdc_info_ctrlport_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FIXED_PRIO     = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] s0_ctrlport_req_addr,
  input  logic [3:0]  s0_ctrlport_req_byte_en,
  input  logic [31:0] s0_ctrlport_req_data,
  input  logic        s0_ctrlport_req_rd,
  input  logic        s0_ctrlport_req_wr,
  output logic        s0_ctrlport_resp_ack,
  output logic [31:0] s0_ctrlport_resp_data,
  output logic [1:0]  s0_ctrlport_resp_status,
  input  logic [19:0] s1_ctrlport_req_addr,
  input  logic [3:0]  s1_ctrlport_req_byte_en,
  input  logic [31:0] s1_ctrlport_req_data,
  input  logic        s1_ctrlport_req_rd,
  input  logic        s1_ctrlport_req_wr,
  output logic        s1_ctrlport_resp_ack,
  output logic [31:0] s1_ctrlport_resp_data,
  output logic [1:0]  s1_ctrlport_resp_status,
  output logic [19:0] m_ctrlport_req_addr,
  output logic [3:0]  m_ctrlport_req_byte_en,
  output logic [31:0] m_ctrlport_req_data,
  output logic        m_ctrlport_req_rd,
  output logic        m_ctrlport_req_wr,
  input  logic        m_ctrlport_resp_ack,
  input  logic [31:0] m_ctrlport_resp_data,
  input  logic [1:0]  m_ctrlport_resp_status,
  output logic [1:0]  overlap_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] rst_sync;
  logic arst_n;
  arb_state_t state, state_nxt;
  logic [1:0] pend, clr;
  slot_t slot [2];
  logic grant, prio, is_wr, timeout, pick;
  logic [TW-1:0] timer;
  logic [31:0] rdata [2];
  logic [1:0] rsts [2];
  // assert immediately, release two clocks after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign arst_n = rst_sync[1];
  rfdc_info_req_slot u_slot0 (
    .clk(clk), .rst_n(arst_n),
    .addr(s0_ctrlport_req_addr), .byte_en(s0_ctrlport_req_byte_en), .data(s0_ctrlport_req_data),
    .rd(s0_ctrlport_req_rd), .wr(s0_ctrlport_req_wr), .clr(clr[0]),
    .pending(pend[0]), .slot(slot[0]), .overlap(overlap_err[0])
  );
  rfdc_info_req_slot u_slot1 (
    .clk(clk), .rst_n(arst_n),
    .addr(s1_ctrlport_req_addr), .byte_en(s1_ctrlport_req_byte_en), .data(s1_ctrlport_req_data),
    .rd(s1_ctrlport_req_rd), .wr(s1_ctrlport_req_wr), .clr(clr[1]),
    .pending(pend[1]), .slot(slot[1]), .overlap(overlap_err[1])
  );
  assign pick    = arb_pick(pend, prio, FIXED_PRIO != 0);
  assign clr     = {state == RESP && grant, state == RESP && !grant};
  assign timeout = timer == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (|pend ? ISSUE : IDLE) :
                state == ISSUE ? WAIT :
                state == WAIT  ? ((m_ctrlport_resp_ack || timeout) ? RESP : WAIT) : IDLE;
  always_comb begin
    m_ctrlport_req_rd    = state == ISSUE && !is_wr;
    m_ctrlport_req_wr    = state == ISSUE && is_wr;
    s0_ctrlport_resp_ack = state == RESP && !grant;
    s1_ctrlport_resp_ack = state == RESP && grant;
  end
  // an ack landing on the last WAIT cycle beats the timeout
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      grant                  <= 1'b0;
      prio                   <= 1'b0;
      is_wr                  <= 1'b0;
      timer                  <= '0;
      m_ctrlport_req_addr    <= '0;
      m_ctrlport_req_byte_en <= '0;
      m_ctrlport_req_data    <= '0;
      rdata                  <= '{default: '0};
      rsts                   <= '{default: '0};
    end else begin
      if (state == IDLE && |pend) begin
        grant                  <= pick;
        is_wr                  <= slot[pick].is_wr;
        m_ctrlport_req_addr    <= slot[pick].addr;
        m_ctrlport_req_byte_en <= slot[pick].byte_en;
        m_ctrlport_req_data    <= slot[pick].data;
      end
      timer <= state == WAIT ? timer + 1'b1 : '0;
      if (state == WAIT && (m_ctrlport_resp_ack || timeout)) begin
        rdata[grant] <= m_ctrlport_resp_ack ? m_ctrlport_resp_data : '0;
        rsts[grant]  <= m_ctrlport_resp_ack ? m_ctrlport_resp_status : CTRL_STS_CMDERR;
      end
      if (state == RESP) prio <= ~grant;
    end
  assign s0_ctrlport_resp_data   = rdata[0];
  assign s0_ctrlport_resp_status = rsts[0];
  assign s1_ctrlport_resp_data   = rdata[1];
  assign s1_ctrlport_resp_status = rsts[1];
endmodule

// File: tb/tb_rfdc_info_ctrlport_arb.sv
// tb_rfdc_info_ctrlport_arb: round-robin and fixed-priority arbiters side by side with a behavioural info memory
module tb_rfdc_info_ctrlport_arb;
  import rfdc_info_ctrlport_arb_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [19:0] s_addr [2];
  logic [3:0]  s_be [2];
  logic [31:0] s_data [2];
  logic        s_rd [2];
  logic        s_wr [2];
  logic        ack [2][2];
  logic [31:0] rdat [2][2];
  logic [1:0]  rsts [2][2];
  logic [1:0]  ovl [2];
  logic [19:0] m_addr [2];
  logic [3:0]  m_be [2];
  logic [31:0] m_data [2];
  logic        m_rd [2];
  logic        m_wr [2];
  logic        m_ack [2];
  logic [31:0] m_rdata [2];
  logic [1:0]  m_sts [2];
  int checks = 0;
  int errors = 0;
  int ack_dly = 1;
  bit no_ack = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rfdc_info_ctrlport_arb #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(g)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_ctrlport_req_addr(s_addr[0]), .s0_ctrlport_req_byte_en(s_be[0]), .s0_ctrlport_req_data(s_data[0]),
      .s0_ctrlport_req_rd(s_rd[0]), .s0_ctrlport_req_wr(s_wr[0]),
      .s0_ctrlport_resp_ack(ack[g][0]), .s0_ctrlport_resp_data(rdat[g][0]), .s0_ctrlport_resp_status(rsts[g][0]),
      .s1_ctrlport_req_addr(s_addr[1]), .s1_ctrlport_req_byte_en(s_be[1]), .s1_ctrlport_req_data(s_data[1]),
      .s1_ctrlport_req_rd(s_rd[1]), .s1_ctrlport_req_wr(s_wr[1]),
      .s1_ctrlport_resp_ack(ack[g][1]), .s1_ctrlport_resp_data(rdat[g][1]), .s1_ctrlport_resp_status(rsts[g][1]),
      .m_ctrlport_req_addr(m_addr[g]), .m_ctrlport_req_byte_en(m_be[g]), .m_ctrlport_req_data(m_data[g]),
      .m_ctrlport_req_rd(m_rd[g]), .m_ctrlport_req_wr(m_wr[g]),
      .m_ctrlport_resp_ack(m_ack[g]), .m_ctrlport_resp_data(m_rdata[g]), .m_ctrlport_resp_status(m_sts[g]),
      .overlap_err(ovl[g])
    );
  end
  function automatic logic [31:0] mem_word(logic [19:0] a);
    return 32'hA500_0000 | 32'(a[19:2]);
  endfunction
  // info memory stub: acks ack_dly cycles after the strobe, writes are rejected
  bit sl_pend [2];
  int sl_cnt [2];
  logic [19:0] sl_addr [2];
  logic sl_wr [2];
  initial for (int i = 0; i < 2; i++) begin
    m_ack[i] = 1'b0; m_rdata[i] = '0; m_sts[i] = '0;
    s_addr[i] = '0; s_be[i] = '0; s_data[i] = '0; s_rd[i] = 1'b0; s_wr[i] = 1'b0;
  end
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      m_ack[i] <= 1'b0;
      if (m_rd[i] || m_wr[i]) begin
        sl_addr[i] <= m_addr[i];
        sl_wr[i]   <= m_wr[i];
        if (!no_ack && ack_dly <= 1) begin
          m_ack[i]   <= 1'b1;
          m_rdata[i] <= m_wr[i] ? 32'h0 : mem_word(m_addr[i]);
          m_sts[i]   <= m_wr[i] ? CTRL_STS_CMDERR : CTRL_STS_OKAY;
          sl_pend[i] <= 1'b0;
        end else begin
          sl_pend[i] <= 1'b1;
          sl_cnt[i]  <= 2;
        end
      end else if (sl_pend[i] && !no_ack) begin
        if (sl_cnt[i] >= ack_dly) begin
          m_ack[i]   <= 1'b1;
          m_rdata[i] <= sl_wr[i] ? 32'h0 : mem_word(sl_addr[i]);
          m_sts[i]   <= sl_wr[i] ? CTRL_STS_CMDERR : CTRL_STS_OKAY;
          sl_pend[i] <= 1'b0;
        end else sl_cnt[i] <= sl_cnt[i] + 1;
      end
    end
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask
  typedef struct {
    int p; bit rd; bit wr; logic [19:0] addr; logic [3:0] be; logic [31:0] data;
    int dly; bit noack; logic [1:0] sts; logic [31:0] rdata; int lat;
  } vec_t;
  vec_t vt [7];
  task automatic txn(input vec_t v, input string tag);
    int ns = 0;
    bit got = 0;
    bit other = 0;
    ack_dly = v.dly;
    no_ack = v.noack;
    @(posedge clk); #1;
    s_addr[v.p] = v.addr; s_be[v.p] = v.be; s_data[v.p] = v.data; s_rd[v.p] = v.rd; s_wr[v.p] = v.wr;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      s_rd[v.p] = 1'b0; s_wr[v.p] = 1'b0;
      @(negedge clk);
      if (m_rd[0] || m_wr[0]) begin
        ns++;
        chk({tag, ".m_req_cycle"}, k, 2);
        chk({tag, ".m_req_addr"}, m_addr[0], v.addr);
        chk({tag, ".m_req_be"}, m_be[0], v.be);
        chk({tag, ".m_req_data"}, m_data[0], v.data);
        chk({tag, ".m_req_wr"}, m_wr[0], v.wr & ~v.rd);
        chk({tag, ".m_req_rd"}, m_rd[0], v.rd);
      end
      if (ack[0][1-v.p]) other = 1;
      if (ack[0][v.p]) begin
        got = 1;
        chk({tag, ".latency"}, k, v.lat);
        chk({tag, ".resp_data"}, rdat[0][v.p], v.rdata);
        chk({tag, ".resp_status"}, rsts[0][v.p], v.sts);
      end
    end
    chk({tag, ".ack_seen"}, got, 1);
    chk({tag, ".strobes"}, ns, 1);
    chk({tag, ".other_ack"}, other, 0);
  endtask
  task automatic pair(input string tag, input int exp0, input int exp1);
    int first [2] = '{-1, -1};
    int cnt [2] = '{0, 0};
    ack_dly = 1;
    no_ack = 0;
    @(posedge clk); #1;
    s_addr[0] = 20'h000; s_addr[1] = 20'h004; s_wr[0] = 1'b0; s_wr[1] = 1'b0; s_rd[0] = 1'b1; s_rd[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      s_rd[0] = 1'b0; s_rd[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (ack[d][p]) begin
            if (first[d] < 0) first[d] = p;
            cnt[d]++;
            chk($sformatf("%s.d%0d.s%0d_data", tag, d, p), rdat[d][p], p ? 32'hA500_0001 : 32'hA500_0000);
          end
    end
    chk({tag, ".rr_first"}, first[0], exp0);
    chk({tag, ".fixed_first"}, first[1], exp1);
    chk({tag, ".rr_count"}, cnt[0], 2);
    chk({tag, ".fixed_count"}, cnt[1], 2);
  endtask
  bit mp [2][2];
  int iss [2];
  logic [19:0] ma [2][2];
  logic [3:0] mb [2][2];
  logic [31:0] md [2][2];
  bit mw [2][2];
  logic [1:0] movl [2];
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cnt;
    bit flag;
    vt[0] = '{0, 1, 0, 20'h00008, 4'hF, 32'h0,         1, 0, CTRL_STS_OKAY,   32'hA500_0002, 4};
    vt[1] = '{1, 0, 1, 20'h00010, 4'h3, 32'hDEAD_BEEF, 1, 0, CTRL_STS_CMDERR, 32'h0,         4};
    vt[2] = '{1, 1, 0, 20'hFFFFC, 4'hF, 32'h0,         3, 0, CTRL_STS_OKAY,   32'hA503_FFFF, 6};
    vt[3] = '{0, 1, 1, 20'h00024, 4'hC, 32'h5555_AAAA, 1, 0, CTRL_STS_OKAY,   32'hA500_0009, 4};
    vt[4] = '{0, 0, 1, 20'h00000, 4'h1, 32'h1234_5678, 2, 0, CTRL_STS_CMDERR, 32'h0,         5};
    vt[5] = '{1, 1, 0, 20'h00004, 4'hF, 32'h0,         8, 0, CTRL_STS_OKAY,   32'hA500_0001, 11};
    vt[6] = '{0, 1, 0, 20'h0000C, 4'hF, 32'h0,         1, 1, CTRL_STS_CMDERR, 32'h0,         11};
    #1;
    @(negedge clk);
    chk("reset.m_rd", m_rd[0], 0);
    chk("reset.m_wr", m_wr[0], 0);
    chk("reset.m_addr", m_addr[0], 0);
    chk("reset.acks", {ack[0][0], ack[0][1]}, 0);
    chk("reset.resp", {rdat[0][0], rsts[0][0], rdat[0][1], rsts[0][1]}, 0);
    chk("reset.overlap", ovl[0], 0);
    do_reset();
    pair("pair0", 0, 0);
    txn(vt[0], "solo");
    pair("pair1", 1, 0);
    for (int i = 0; i < 7; i++) txn(vt[i], $sformatf("vec%0d", i));
    // the stub now delivers the ack the timeout already gave up on
    no_ack = 0;
    flag = 0; cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_ack[0]) cnt++;
      if (ack[0][0] || ack[0][1]) flag = 1;
    end
    chk("late_ack.delivered", cnt, 1);
    chk("late_ack.ignored", flag, 0);
    do_reset();
    ack_dly = 4;
    @(posedge clk); #1;
    s_addr[0] = 20'h008; s_rd[0] = 1'b1;
    @(posedge clk); #1; s_rd[0] = 1'b0;
    @(posedge clk); #1; s_addr[0] = 20'h00C; s_rd[0] = 1'b1;
    @(posedge clk); #1; s_rd[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (ack[0][0]) begin
        cnt++;
        chk("overlap.data", rdat[0][0], 32'hA500_0002);
      end
    end
    chk("overlap.ack_count", cnt, 1);
    chk("overlap.err_rr", ovl[0], 2'b01);
    chk("overlap.err_fixed", ovl[1], 2'b01);
    ack_dly = 6;
    @(posedge clk); #1;
    s_addr[0] = 20'h008; s_rd[0] = 1'b1;
    @(posedge clk); #1; s_rd[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwait.m_addr_before", m_addr[0], 20'h008);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstwait.m_addr", m_addr[0], 0);
    chk("rstwait.strobes", {m_rd[0], m_wr[0]}, 0);
    chk("rstwait.resp", {rdat[0][0], rsts[0][0], ack[0][0], ack[0][1]}, 0);
    chk("rstwait.overlap", ovl[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    flag = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ack[0][0] || ack[0][1]) flag = 1;
    end
    chk("rstwait.no_ack", flag, 0);
    txn('{0, 1, 0, 20'h00014, 4'hF, 32'h0, 1, 0, CTRL_STS_OKAY, 32'hA500_0005, 4}, "fresh");
    iss = '{-1, -1};
    movl = '{2'b00, 2'b00};
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      ack_dly = $urandom_range(1, 7);
      for (int p = 0; p < 2; p++) begin
        s_rd[p] = 1'b0; s_wr[p] = 1'b0;
        if (cyc < 360 && $urandom_range(0, 3) == 0) begin
          int typ = $urandom_range(0, 2);
          s_addr[p] = 20'($urandom); s_be[p] = 4'($urandom); s_data[p] = $urandom;
          s_rd[p] = typ != 1; s_wr[p] = typ != 0;
          for (int d = 0; d < 2; d++)
            if (mp[d][p]) movl[d][p] = 1'b1;
            else begin
              mp[d][p] = 1; ma[d][p] = s_addr[p]; mb[d][p] = s_be[p]; md[d][p] = s_data[p]; mw[d][p] = typ == 1;
            end
        end
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (m_rd[d] || m_wr[d]) begin
          int q = -1;
          for (int p = 0; p < 2; p++)
            if (mp[d][p] && m_addr[d] == ma[d][p] && m_be[d] == mb[d][p] && m_data[d] == md[d][p] &&
                m_wr[d] == mw[d][p] && m_rd[d] == !mw[d][p]) q = p;
          chk($sformatf("rnd.d%0d.m_req_match", d), q >= 0 && iss[d] < 0, 1);
          iss[d] = q;
        end
        for (int p = 0; p < 2; p++)
          if (ack[d][p]) begin
            chk($sformatf("rnd.d%0d.s%0d_ack_expected", d, p), mp[d][p] && iss[d] == p, 1);
            chk($sformatf("rnd.d%0d.s%0d_data", d, p), rdat[d][p], mw[d][p] ? 32'h0 : mem_word(ma[d][p]));
            chk($sformatf("rnd.d%0d.s%0d_status", d, p), rsts[d][p], mw[d][p] ? CTRL_STS_CMDERR : CTRL_STS_OKAY);
            mp[d][p] = 0;
            iss[d] = -1;
          end
      end
    end
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rnd.d%0d.drained", d), {mp[d][1], mp[d][0]}, 0);
      chk($sformatf("rnd.d%0d.overlap", d), ovl[d], movl[d]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
